// File: rtl/arb_grant_buffer.sv
// Registered {idx, data} FIFO between the round-robin arbiter and its consumer.
// Throttles the arbiter through arb_en_o so an issued grant is never dropped.
module arb_grant_buffer #(
  parameter int NUM_REQ    = 64,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  localparam int IDX_W     = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   data_i,
  input  logic                                 arb_vld_i,
  input  logic [IDX_W-1:0]                     arb_idx_i,
  output logic                                 arb_en_o,
  output logic                                 valid_o,
  input  logic                                 ready_i,
  output logic [IDX_W-1:0]                     idx_o,
  output logic [DATA_WIDTH-1:0]                data_o,
  output logic [CNT_W-1:0]                     count_o
);

  localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [IDX_W-1:0]      mem_idx  [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic                  clear;
  logic                  push;
  logic                  pop;
  logic                  not_empty;
  logic [DATA_WIDTH-1:0] win_data;

  assign clear     = rst_i | flush_i;
  assign not_empty = (count != '0);

  // Enable is a function of occupancy and clear only, keeping ready_i off this path.
  assign arb_en_o  = (count < CNT_FULL) & ~clear;
  assign push      = arb_vld_i & arb_en_o;
  assign pop       = not_empty & ready_i & ~clear;

  always_comb begin
    win_data = '0;
    if (int'(arb_idx_i) < NUM_REQ) begin
      win_data = data_i[arb_idx_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; outputs are masked while empty instead.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_idx[wr_ptr]  <= arb_idx_i;
      mem_data[wr_ptr] <= win_data;
    end
  end

  assign valid_o = not_empty;
  assign count_o = count;
  assign idx_o   = not_empty ? mem_idx[rd_ptr]  : '0;
  assign data_o  = not_empty ? mem_data[rd_ptr] : '0;

endmodule

// File: tb/tb_arb_grant_buffer.sv
// Drives three buffer instances (DEPTH 2, 3, 1) with shared stimulus and
// compares every output each cycle against a queue-based reference model.
module tb_arb_grant_buffer;

  localparam int NR = 16;
  localparam int DW = 16;
  localparam int IW = 4;
  localparam int DEP [3] = '{2, 3, 1};

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   flush = 1'b0;
  logic [NR-1:0][DW-1:0]  data = '0;
  logic                   vld = 1'b0;
  logic [IW-1:0]          idx = '0;
  logic                   ready = 1'b0;

  logic          en0, en1, en2;
  logic          val0, val1, val2;
  logic [IW-1:0] idxo0, idxo1, idxo2;
  logic [DW-1:0] dato0, dato1, dato2;
  logic [1:0]    cnt0, cnt1;
  logic [0:0]    cnt2;

  logic [IW+DW-1:0] mq [3][$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  arb_grant_buffer #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(2)) u_d2 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(data), .arb_vld_i(vld),
    .arb_idx_i(idx), .arb_en_o(en0), .valid_o(val0), .ready_i(ready),
    .idx_o(idxo0), .data_o(dato0), .count_o(cnt0));

  arb_grant_buffer #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(3)) u_d3 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(data), .arb_vld_i(vld),
    .arb_idx_i(idx), .arb_en_o(en1), .valid_o(val1), .ready_i(ready),
    .idx_o(idxo1), .data_o(dato1), .count_o(cnt1));

  arb_grant_buffer #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(1)) u_d1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(data), .arb_vld_i(vld),
    .arb_idx_i(idx), .arb_en_o(en2), .valid_o(val2), .ready_i(ready),
    .idx_o(idxo2), .data_o(dato2), .count_o(cnt2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic get_outs(input int i, output logic e, output logic v,
                          output logic [IW-1:0] ix, output logic [DW-1:0] d,
                          output logic [1:0] c);
    case (i)
      0:       begin e = en0; v = val0; ix = idxo0; d = dato0; c = cnt0; end
      1:       begin e = en1; v = val1; ix = idxo1; d = dato1; c = cnt1; end
      default: begin e = en2; v = val2; ix = idxo2; d = dato2; c = {1'b0, cnt2}; end
    endcase
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic step();
    logic          e, v;
    logic [IW-1:0] ix;
    logic [DW-1:0] d;
    logic [1:0]    c;
    logic [IW+DW-1:0] head;
    logic          en_exp [3];
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      int sz = mq[i].size();
      head = (sz != 0) ? mq[i][0] : '0;
      en_exp[i] = (sz < DEP[i]) && !rst && !flush;
      get_outs(i, e, v, ix, d, c);
      check($sformatf("d%0d_en", DEP[i]),    32'(e),  32'(en_exp[i]));
      check($sformatf("d%0d_valid", DEP[i]), 32'(v),  32'(sz != 0));
      check($sformatf("d%0d_count", DEP[i]), 32'(c),  32'(sz));
      check($sformatf("d%0d_idx", DEP[i]),   32'(ix), 32'(head[IW+DW-1:DW]));
      check($sformatf("d%0d_data", DEP[i]),  32'(d),  32'(head[DW-1:0]));
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst || flush) begin
        mq[i].delete();
      end else begin
        bit do_pop  = (mq[i].size() != 0) && ready;
        bit do_push = vld && en_exp[i];
        if (do_pop)  void'(mq[i].pop_front());
        if (do_push) mq[i].push_back({idx, data[idx]});
      end
    end
    #1;
  endtask

  task automatic randomize_data();
    for (int k = 0; k < NR; k++) data[k] = DW'($urandom);
  endtask

  initial begin
    // Reset held with a grant pending: nothing may be accepted.
    rst = 1'b1; vld = 1'b1; idx = 4'd3; randomize_data();
    repeat (3) step();
    rst = 1'b0; vld = 1'b0;
    #1;
    check("en_after_reset", 32'(en0), 32'd1);
    step();

    // Streaming grants 0..9, ready held high.
    ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      randomize_data();
      vld = 1'b1; idx = IW'(k); data[k] = DW'(16'hA000 + k);
      step();
      check("stream_d2_count", 32'(cnt0), 32'd1);
      check("stream_d2_idx",   32'(idxo0), 32'(k));
      check("stream_d2_data",  32'(dato0), 32'(16'hA000 + k));
    end
    vld = 1'b0;
    repeat (3) step();

    // Backpressure: fill DEPTH=2, extra grant ignored, head held.
    ready = 1'b0;
    vld = 1'b1; idx = 4'd5; randomize_data(); step();
    idx = 4'd7; randomize_data(); step();
    idx = 4'd9; randomize_data(); step();
    check("bp_count", 32'(cnt0), 32'd2);
    check("bp_en",    32'(en0),  32'd0);
    check("bp_head",  32'(idxo0), 32'd5);
    step();
    check("bp_hold",  32'(idxo0), 32'd5);
    vld = 1'b0; ready = 1'b1; step();
    check("bp_en_ret", 32'(en0),  32'd1);
    check("bp_second", 32'(idxo0), 32'd7);
    repeat (4) step();

    // Flush colliding with a grant and a pop.
    ready = 1'b0; vld = 1'b1;
    idx = 4'd3; randomize_data(); step();
    idx = 4'd4; randomize_data(); step();
    check("fl_pre_count", 32'(cnt0), 32'd2);
    flush = 1'b1; ready = 1'b1; idx = 4'd6; randomize_data(); step();
    flush = 1'b0; vld = 1'b0;
    check("fl_count", 32'(cnt0),  32'd0);
    check("fl_valid", 32'(val0),  32'd0);
    check("fl_data",  32'(dato0), 32'd0);
    repeat (2) step();

    // DEPTH=1 under continuous grants: enable alternates.
    ready = 1'b1; vld = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      idx = IW'($urandom_range(0, NR - 1)); randomize_data();
      step();
      check("d1_toggle", 32'(en2), 32'((k % 2) == 0));
    end
    vld = 1'b0;
    repeat (3) step();

    // Random traffic with occasional flush and reset.
    for (int n = 0; n < 400; n++) begin
      randomize_data();
      vld   = ($urandom_range(0, 3) != 0);
      idx   = IW'($urandom_range(0, NR - 1));
      ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 31) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0; vld = 1'b0; ready = 1'b1;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
